wb_stage_skid_reg: RTL and testbench
====================================

// Module: wb_stage_skid_reg
// PURPOSE
// - Elastic MEM->WB pipeline stage. It replaces the fixed free-running stage register with a
//   parametrised 2-entry skid buffer that uses a valid/ready handshake.
// - Adds stall back-pressure, synchronous flush and x0-write suppression.
// - Sits between data-memory access and register-file writeback; WB consumes the head entry.
// PARAMETERS
// - XLEN    64  width of mem_data and alu_result
// - RADDR_W 5   width of rd (register index)
// PORTS
// - clk            in   1        rising-edge clock (only clock)
// - rst            in   1        asynchronous, active-high reset
// - flush          in   1        synchronous flush; discards all entries
// - in_valid       in   1        MEM side offers an entry
// - in_ready       out  1        stage can accept an entry this cycle
// - in_mem_data    in   XLEN     load data
// - in_alu_result  in   XLEN     ALU result
// - in_rd          in   RADDR_W  destination register
// - in_mem_to_reg  in   1        1 = write back load data
// - in_reg_write   in   1        register-file write enable
// - out_valid      out  1        head entry valid toward WB
// - out_ready      in   1        WB consumes head this cycle
// - out_mem_data   out  XLEN     head fields (registered)
// - out_alu_result out  XLEN
// - out_rd         out  RADDR_W
// - out_mem_to_reg out  1
// - out_reg_write  out  1
// - occupancy      out  2        entries held: 0, 1 or 2
// BEHAVIOUR
// - Entry storage: head register drives out_* directly; skid register holds the second entry.
// - push = in_valid & in_ready.
// - pop  = out_valid & out_ready.
// - State machine (state is encoded as occupancy):
//   - EMPTY (0):
//     - push -> ONE; head <= in.
//   - ONE (1):
//     - push & pop -> ONE; head <= in.
//     - push only -> FULL; skid <= in.
//     - pop only -> EMPTY.
//   - FULL (2):
//     - pop -> ONE; head <= skid.
//     - No push is possible.
// - Derived signals:
//   - in_ready = (state != FULL). Depends only on state, with no comb path from out_ready.
//   - out_valid = (state != EMPTY).
// - Latency: an entry pushed in cycle N is on out_* with out_valid=1 in cycle N+1 when empty.
// - Throughput: one entry per cycle while out_ready=1.
// - x0 suppression: at capture, reg_write is stored as in_reg_write & (in_rd != 0).
// - Flush: synchronous and highest priority.
//   - Next state is EMPTY. A push or pop in the same cycle is ignored.
//   - Data registers keep their contents. Only the valid state is cleared.
// - Reset (async, rst=1), any state:
//   - state=EMPTY, all out_* = 0, occupancy = 0.
//   - in_ready = 1 from the first cycle after rst deasserts.
// - Stability: out_* hold their value while out_valid=1 and out_ready=0.
// - Control is ignored unless its gating condition holds:
//   - in_valid with in_ready=0 has no effect.
//   - out_ready with out_valid=0 has no effect.
// CONFIGURATION
// - Macro WB_STAGE_FWD_EN:
//   - Defined: adds output ports
//       fwd_valid  1     = out_valid & out_reg_write
//       fwd_rd     RADDR_W = out_rd
//       fwd_data   XLEN  = out_mem_to_reg ? out_mem_data : out_alu_result
//   - fwd_* are combinational from the head entry and feed the EX forwarding mux. Reset value 0.
//   - Not defined: the fwd_* ports do not exist. Behaviour is otherwise identical.
// TESTING
// - Reset: rst=1 mid-FULL -> next clk out_valid=0, occupancy=0, out_*=0. After release, in_ready=1.
// - Pass-through: out_ready=1, push rd=5, alu=0x10, reg_write=1 ->
//   next cycle out_valid=1, out_rd=5, out_alu_result=0x10.
// - Stall: out_ready=0, push A, B ->
//   - occupancy=2, in_ready=0, out=A held.
//   - Set out_ready=1 -> out=A, then B, then occupancy=0.
// - x0 write: push rd=0, reg_write=1 -> out_reg_write=0.
//   With WB_STAGE_FWD_EN: fwd_valid=0.
// - Flush: FULL with in_valid=1 and flush=1 -> next cycle occupancy=0, out_valid=0, nothing captured.
// - Forwarding (WB_STAGE_FWD_EN): head has mem_to_reg=1, mem_data=0xDEAD, rd=7, reg_write=1 ->
//   fwd_valid=1, fwd_rd=7, fwd_data=0xDEAD.

Source files
------------

// File: rtl/wb_stage_skid_reg_if.sv
// MEM->WB handshake bundle: MEM-side offer (in_*) and WB-side head entry (out_*).
// The stage connects through the slave modport, and its environment through the master modport.
interface wb_stage_skid_reg_if #(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned RADDR_W = 5
);
   logic               in_valid;
   logic               in_ready;
   logic [XLEN-1:0]    in_mem_data;
   logic [XLEN-1:0]    in_alu_result;
   logic [RADDR_W-1:0] in_rd;
   logic               in_mem_to_reg;
   logic               in_reg_write;

   logic               out_valid;
   logic               out_ready;
   logic [XLEN-1:0]    out_mem_data;
   logic [XLEN-1:0]    out_alu_result;
   logic [RADDR_W-1:0] out_rd;
   logic               out_mem_to_reg;
   logic               out_reg_write;

   modport master (
      output in_valid, in_mem_data, in_alu_result, in_rd, in_mem_to_reg, in_reg_write,
      input  in_ready,
      input  out_valid, out_mem_data, out_alu_result, out_rd, out_mem_to_reg, out_reg_write,
      output out_ready
   );

   modport slave (
      input  in_valid, in_mem_data, in_alu_result, in_rd, in_mem_to_reg, in_reg_write,
      output in_ready,
      output out_valid, out_mem_data, out_alu_result, out_rd, out_mem_to_reg, out_reg_write,
      input  out_ready
   );
endinterface

// File: rtl/wb_stage_skid_reg.sv
// Elastic MEM->WB stage: a 2-entry skid buffer (head + skid) with flush and x0-write suppression.
// Define WB_STAGE_FWD_EN to add the fwd_* ports that feed the EX forwarding mux from the head.
module wb_stage_skid_reg #(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned RADDR_W = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   wb_stage_skid_reg_if.slave  bus,
   output logic [1:0]          occupancy
`ifdef WB_STAGE_FWD_EN
   ,
   output logic                fwd_valid,
   output logic [RADDR_W-1:0]  fwd_rd,
   output logic [XLEN-1:0]     fwd_data
`endif
);

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StFull  = 2'd2
   } state_e;

   typedef struct packed {
      logic [XLEN-1:0]    mem_data;
      logic [XLEN-1:0]    alu_result;
      logic [RADDR_W-1:0] rd;
      logic               mem_to_reg;
      logic               reg_write;
   } entry_t;

   state_e state_q, state_d;
   entry_t head_q, head_d;
   entry_t skid_q, skid_d;
   entry_t in_entry;
   logic   push, pop;

   always_comb begin
      in_entry.mem_data   = bus.in_mem_data;
      in_entry.alu_result = bus.in_alu_result;
      in_entry.rd         = bus.in_rd;
      in_entry.mem_to_reg = bus.in_mem_to_reg;
      // Writes to x0 are dropped at capture so WB and forwarding never see them.
      in_entry.reg_write  = bus.in_reg_write & (bus.in_rd != '0);
   end

   always_comb begin
      bus.in_ready  = (state_q != StFull);
      bus.out_valid = (state_q != StEmpty);
      push          = bus.in_valid & bus.in_ready;
      pop           = bus.out_valid & bus.out_ready;
   end

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      if (flush) begin
         // Only the valid state is cleared; data registers keep their contents.
         state_d = StEmpty;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (push) begin
                  head_d  = in_entry;
                  state_d = StOne;
               end
            end
            StOne: begin
               if (push && pop) begin
                  head_d = in_entry;
               end else if (push) begin
                  skid_d  = in_entry;
                  state_d = StFull;
               end else if (pop) begin
                  state_d = StEmpty;
               end
            end
            StFull: begin
               if (pop) begin
                  head_d  = skid_q;
                  state_d = StOne;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StEmpty;
         head_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
      end
   end

   always_comb begin
      bus.out_mem_data   = head_q.mem_data;
      bus.out_alu_result = head_q.alu_result;
      bus.out_rd         = head_q.rd;
      bus.out_mem_to_reg = head_q.mem_to_reg;
      bus.out_reg_write  = head_q.reg_write;
      occupancy          = state_q;
   end

`ifdef WB_STAGE_FWD_EN
   always_comb begin
      fwd_valid = bus.out_valid & head_q.reg_write;
      fwd_rd    = head_q.rd;
      fwd_data  = head_q.mem_to_reg ? head_q.mem_data : head_q.alu_result;
   end
`endif

endmodule

// File: tb/tb_wb_stage_skid_reg.sv
// Self-checking bench for wb_stage_skid_reg: vector table, corner sequences and random traffic
// checked against a queue model of the two-entry buffer.
module tb_wb_stage_skid_reg;
   localparam int unsigned XLEN    = 64;
   localparam int unsigned RADDR_W = 5;

   typedef struct {
      logic               iv;
      logic               ordy;
      logic               fl;
      logic [RADDR_W-1:0] rd;
      logic [XLEN-1:0]    alu;
      logic [XLEN-1:0]    mem;
      logic               m2r;
      logic               rw;
   } vec_t;

   typedef struct {
      logic [XLEN-1:0]    mem;
      logic [XLEN-1:0]    alu;
      logic [RADDR_W-1:0] rd;
      logic               m2r;
      logic               rw;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush;
   logic [1:0] occupancy;
`ifdef WB_STAGE_FWD_EN
   logic               fwd_valid;
   logic [RADDR_W-1:0] fwd_rd;
   logic [XLEN-1:0]    fwd_data;
`endif

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];
   vec_t vecs[19];

   wb_stage_skid_reg_if #(.XLEN(XLEN), .RADDR_W(RADDR_W)) bus ();

   wb_stage_skid_reg #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .bus       (bus),
      .occupancy (occupancy)
`ifdef WB_STAGE_FWD_EN
      ,
      .fwd_valid (fwd_valid),
      .fwd_rd    (fwd_rd),
      .fwd_data  (fwd_data)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic iv, input logic ordy, input logic fl,
                               input logic [RADDR_W-1:0] rd, input logic [XLEN-1:0] alu,
                               input logic [XLEN-1:0] mem, input logic m2r, input logic rw);
      vec_t v;
      v.iv = iv; v.ordy = ordy; v.fl = fl; v.rd = rd;
      v.alu = alu; v.mem = mem; v.m2r = m2r; v.rw = rw;
      return v;
   endfunction

   task automatic check_outputs(input bit zeros);
      int occ;
      occ = sb.size();
      chk("in_ready", bus.in_ready, (occ != 2));
      chk("out_valid", bus.out_valid, (occ != 0));
      chk("occupancy", occupancy, occ);
      if (zeros) begin
         chk("rst_mem_data", bus.out_mem_data, 0);
         chk("rst_alu_result", bus.out_alu_result, 0);
         chk("rst_rd", bus.out_rd, 0);
         chk("rst_mem_to_reg", bus.out_mem_to_reg, 0);
         chk("rst_reg_write", bus.out_reg_write, 0);
      end else if (occ > 0) begin
         chk("out_mem_data", bus.out_mem_data, sb[0].mem);
         chk("out_alu_result", bus.out_alu_result, sb[0].alu);
         chk("out_rd", bus.out_rd, sb[0].rd);
         chk("out_mem_to_reg", bus.out_mem_to_reg, sb[0].m2r);
         chk("out_reg_write", bus.out_reg_write, sb[0].rw);
      end
`ifdef WB_STAGE_FWD_EN
      chk("fwd_valid", fwd_valid, (occ > 0) && sb[0].rw);
      if (occ > 0) begin
         chk("fwd_rd", fwd_rd, sb[0].rd);
         chk("fwd_data", fwd_data, sb[0].m2r ? sb[0].mem : sb[0].alu);
      end
`endif
   endtask

   // One cycle: drive at negedge, check the settled state, then advance the model.
   task automatic step(input vec_t v);
      exp_t e;
      bit   push, pop;
      @(negedge clk);
      bus.in_valid      = v.iv;
      bus.out_ready     = v.ordy;
      flush             = v.fl;
      bus.in_rd         = v.rd;
      bus.in_alu_result = v.alu;
      bus.in_mem_data   = v.mem;
      bus.in_mem_to_reg = v.m2r;
      bus.in_reg_write  = v.rw;
      #1;
      check_outputs(1'b0);
      push = v.iv && (sb.size() < 2);
      pop  = v.ordy && (sb.size() > 0);
      e.mem = v.mem; e.alu = v.alu; e.rd = v.rd; e.m2r = v.m2r;
      e.rw  = v.rw && (v.rd != 0);
      if (v.fl) begin
         sb.delete();
      end else begin
         if (pop) void'(sb.pop_front());
         if (push) sb.push_back(e);
      end
   endtask

   initial begin
      vecs[0]  = mk(1, 1, 0, 5'd5, 64'h10, 64'h0, 0, 1);     // pass-through
      vecs[1]  = mk(0, 1, 0, 5'd0, 64'h0, 64'h0, 0, 0);
      vecs[2]  = mk(0, 1, 0, 5'd0, 64'h0, 64'h0, 0, 0);      // out_ready while empty
      vecs[3]  = mk(1, 0, 0, 5'd3, 64'hA, 64'hA0, 0, 1);     // stall: A
      vecs[4]  = mk(1, 0, 0, 5'd4, 64'hB, 64'hB0, 1, 1);     // B -> full
      vecs[5]  = mk(1, 0, 0, 5'd6, 64'hC, 64'hC0, 0, 1);     // rejected while full
      vecs[6]  = mk(0, 1, 0, 5'd0, 64'h0, 64'h0, 0, 0);
      vecs[7]  = mk(0, 1, 0, 5'd0, 64'h0, 64'h0, 0, 0);
      vecs[8]  = mk(0, 1, 0, 5'd0, 64'h0, 64'h0, 0, 0);
      vecs[9]  = mk(1, 1, 0, 5'd0, 64'h55, 64'h66, 0, 1);    // x0 write
      vecs[10] = mk(0, 1, 0, 5'd0, 64'h0, 64'h0, 0, 0);
      vecs[11] = mk(1, 0, 0, 5'd7, 64'h1234, 64'hDEAD, 1, 1);
      vecs[12] = mk(0, 0, 0, 5'd0, 64'h0, 64'h0, 0, 0);
      vecs[13] = mk(1, 0, 0, 5'd8, 64'h88, 64'h0, 0, 1);
      vecs[14] = mk(1, 1, 1, 5'd9, 64'h99, 64'h0, 0, 1);     // flush while full
      vecs[15] = mk(0, 1, 0, 5'd0, 64'h0, 64'h0, 0, 0);
      vecs[16] = mk(1, 1, 0, 5'd9, 64'h90, 64'h0, 0, 1);
      vecs[17] = mk(1, 1, 0, 5'd10, 64'h100, 64'h0, 0, 0);   // push & pop in ONE
      vecs[18] = mk(0, 1, 0, 5'd0, 64'h0, 64'h0, 0, 0);

      bus.in_valid = 0; bus.out_ready = 0; flush = 0;
      bus.in_rd = '0; bus.in_alu_result = '0; bus.in_mem_data = '0;
      bus.in_mem_to_reg = 0; bus.in_reg_write = 0;
      @(negedge clk);
      #1;
      check_outputs(1'b1);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) step(vecs[i]);

      // Reset asserted while FULL.
      step(mk(1, 0, 0, 5'd11, 64'h111, 64'h0, 0, 1));
      step(mk(1, 0, 0, 5'd12, 64'h122, 64'h0, 0, 1));
      @(negedge clk);
      bus.in_valid = 0;
      rst = 1'b1;
      sb.delete();
      #1;
      check_outputs(1'b1);
      @(negedge clk);
      rst = 1'b0;
      step(mk(0, 0, 0, 5'd0, 64'h0, 64'h0, 0, 0));

      for (int i = 0; i < 300; i++) begin
         step(mk($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 31) == 0, RADDR_W'($urandom_range(0, 31)),
                 {$urandom, $urandom}, {$urandom, $urandom},
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
